// File: rtl/button_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : State encoding and counter sizing helper for button_debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  localparam logic [1:0] c_ST_IDLE         = 2'd0;
  localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] c_ST_PRESSED      = 2'd2;
  localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

  // Width of the shared counter: large enough for the biggest compare value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchroniser, async active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Push-button synchroniser/debouncer with press/release pulses
//                and optional auto-repeat (macro BTN_AUTOREPEAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import btn_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic level,
  output logic press,
  output logic release_p,
  output logic repeat_p
);

  localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               w_btn_n;
  logic               w_btn_s;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [c_CNT_W-1:0] w_hold_cnt;
  logic               w_deb_done;
  logic               w_rep_hit;
  logic               w_press;
  logic               w_release;
  logic               w_repeat;
  logic               w_level;

  generate
    if (ACTIVE_LOW) begin : g_active_low
      assign w_btn_n = ~button;
    end else begin : g_active_high
      assign w_btn_n = button;
    end
  endgenerate

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_btn_n),
    .o_q     (w_btn_s)
  );

  assign w_cnt_inc  = r_cnt + c_ONE;
  assign w_deb_done = (r_cnt == c_DEB_LAST);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [c_CNT_W-1:0] c_REP_DELAY  = c_CNT_W'(REPEAT_DELAY);
  localparam logic [c_CNT_W-1:0] c_REP_PERIOD = c_CNT_W'(REPEAT_PERIOD);

  // Phase 0 waits out the initial delay, phase 1 runs the periodic interval.
  logic r_rep_phase;
  logic w_rep_phase_nxt;

  always_comb begin
    w_rep_hit       = 1'b0;
    w_hold_cnt      = w_cnt_inc;
    w_rep_phase_nxt = r_rep_phase;
    if ((r_state != c_ST_PRESSED) || !w_btn_s) begin
      w_rep_phase_nxt = 1'b0;
    end else if (w_cnt_inc == (r_rep_phase ? c_REP_PERIOD : c_REP_DELAY)) begin
      w_rep_hit       = 1'b1;
      w_hold_cnt      = '0;
      w_rep_phase_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rep_phase <= 1'b0;
    else          r_rep_phase <= w_rep_phase_nxt;
  end
`else
  assign w_rep_hit  = 1'b0;
  assign w_hold_cnt = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = c_ST_PRESS_WAIT;
          w_cnt_nxt   = c_ONE;
        end
      end
      c_ST_PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_deb_done) begin
          w_state_nxt = c_ST_PRESSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      c_ST_PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = c_ST_RELEASE_WAIT;
          w_cnt_nxt   = c_ONE;
        end else begin
          w_cnt_nxt   = w_hold_cnt;
        end
      end
      c_ST_RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = c_ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_deb_done) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_press   = (r_state == c_ST_PRESS_WAIT) && w_btn_s && w_deb_done;
    w_release = (r_state == c_ST_RELEASE_WAIT) && !w_btn_s && w_deb_done;
    w_repeat  = w_rep_hit;
    w_level   = (w_state_nxt == c_ST_PRESSED) || (w_state_nxt == c_ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      level     <= w_level;
      press     <= w_press;
      release_p <= w_release;
      repeat_p  <= w_repeat;
    end
  end

endmodule
`default_nettype wire
